// File: rtl/and_share_pkg.sv
// Shared definitions for the round-robin AND-sharing arbiter.
package and_share_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_EXEC = ST_EXEC,
    S_RESP = ST_RESP
  } state_t;

  // Response id width; never narrower than one bit
  function automatic int idw_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/and_unit.sv
// Shared combinational WIDTH-bit bitwise AND resource.
module and_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a & b;

endmodule

// File: rtl/and_share_arbiter.sv
// Round-robin arbiter sharing one AND unit among NREQ requesters.
// One transaction at a time: IDLE grants, EXEC computes, RESP holds result.
module and_share_arbiter
  import and_share_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IDW   = idw_of(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_y,
  output logic [IDW-1:0]        resp_id
);

  state_t                state;
  logic [IDW-1:0]        last_grant;
  logic [WIDTH-1:0]      cap_a;
  logic [WIDTH-1:0]      cap_b;
  logic [IDW-1:0]        cap_id;
  logic [WIDTH-1:0]      and_y;

  logic [2*NREQ-1:0]     dbl;
  logic [NREQ-1:0]       rot;
  logic                  found;
  int                    off;
  int                    win;
  logic [IDW-1:0]        win_id;
  logic                  grant;
  logic [WIDTH-1:0]      sel_a;
  logic [WIDTH-1:0]      sel_b;

  // Round-robin pick: rotate requests so bit 0 is last_grant+1, take lowest set bit
  always_comb begin
    dbl   = {req_valid, req_valid} >> (int'(last_grant) + 1);
    rot   = dbl[NREQ-1:0];
    found = 1'b0;
    off   = 0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      if (rot[o]) begin
        found = 1'b1;
        off   = o;
      end
    end
    win    = (int'(last_grant) + 1 + off) % NREQ;
    win_id = IDW'(win);
  end

  // Grant strobe and winner operand select; ready only in IDLE and out of reset
  always_comb begin
    grant     = rst_n && (state == S_IDLE) && found;
    req_ready = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        req_ready[i] = grant;
        sel_a        = req_a[i*WIDTH +: WIDTH];
        sel_b        = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Operand capture on grant; data path carries no reset
  always_ff @(posedge clk) begin
    if (grant) begin
      cap_a  <= sel_a;
      cap_b  <= sel_b;
      cap_id <= win_id;
    end
  end

  and_unit #(
    .WIDTH (WIDTH)
  ) u_and_unit (
    .a (cap_a),
    .b (cap_b),
    .y (and_y)
  );

  // Transaction FSM with registered response outputs and priority pointer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      resp_valid <= 1'b0;
      resp_y     <= '0;
      resp_id    <= '0;
      last_grant <= IDW'(NREQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (found) state <= S_EXEC;
        end
        S_EXEC: begin
          resp_y     <= and_y;
          resp_id    <= cap_id;
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          // Pointer advances only once the response is consumed
          if (resp_ready) begin
            resp_valid <= 1'b0;
            last_grant <= resp_id;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_share_arbiter.sv
// Scoreboard testbench for and_share_arbiter (NREQ=4, WIDTH=8).
module tb_and_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_y;
  logic [1:0]  resp_id;

  int checks = 0;
  int fails  = 0;

  int         exp_id_q[$];
  logic [7:0] exp_y_q[$];

  // Hand-computed a&b per requester:
  // 0: AA&0F=0A  1: 55&FF=55  2: F0&3C=30  3: C3&81=81
  logic [7:0] exp_y_tbl [4] = '{8'h0A, 8'h55, 8'h30, 8'h81};

  and_share_arbiter #(
    .NREQ  (4),
    .WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_y     (resp_y),
    .resp_id    (resp_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: pop and compare on every response handshake
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
        if (exp_id_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_resp: got id %0d y %0h expected no response at %0t",
                   resp_id, resp_y, $time);
        end else begin
          int         eid;
          logic [7:0] ey;
          eid = exp_id_q.pop_front();
          ey  = exp_y_q.pop_front();
          check("resp_id", 32'(resp_id), 32'(eid));
          check("resp_y", 32'(resp_y), 32'(ey));
        end
      end
    end
  end

  task automatic drain();
    int w = 0;
    while (exp_id_q.size() != 0 && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("drain", 32'(exp_id_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  // Hold vld, expect grants in order ids[0..n-1]; drop vld after the last accept
  task automatic run_seq(input logic [3:0] vld, input int n, input int ids [5]);
    req_valid = vld;
    for (int j = 0; j < n; j++) begin
      int waited = 0;
      @(negedge clk);
      while (req_ready == 4'b0 && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      check("grant", 32'(req_ready), 32'(1 << ids[j]));
      exp_id_q.push_back(ids[j]);
      exp_y_q.push_back(exp_y_tbl[ids[j]]);
      @(posedge clk); #1;
      if (j == n - 1) req_valid = 4'b0;
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    req_a      = {8'hC3, 8'hF0, 8'h55, 8'hAA};
    req_b      = {8'h81, 8'h3C, 8'hFF, 8'h0F};

    // Reset held with all requests pending
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_y", 32'(resp_y), 32'd0);
      check("rst_resp_id", 32'(resp_id), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 4'b0;
    rst_n     = 1'b1;
    @(posedge clk); #1;

    // Single request from requester 2
    run_seq(4'b0100, 1, '{2, 0, 0, 0, 0});

    // Wrap and skip: 3, then 0 (wrap), then 3 (skip 1,2)
    run_seq(4'b1000, 1, '{3, 0, 0, 0, 0});
    run_seq(4'b1001, 2, '{0, 3, 0, 0, 0});

    // Fairness with all requesting
    run_seq(4'b1111, 5, '{0, 1, 2, 3, 0});

    // Backpressure: requester 1, consumer stalls 10 cycles
    req_valid = 4'b0010;
    @(negedge clk);
    check("bp_grant", 32'(req_ready), 32'b0010);
    exp_id_q.push_back(1);
    exp_y_q.push_back(exp_y_tbl[1]);
    @(posedge clk); #1;
    req_valid  = 4'b1101;
    resp_ready = 1'b0;
    begin
      int w = 0;
      @(negedge clk);
      while (resp_valid !== 1'b1 && w < 10) begin
        @(negedge clk);
        w++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(resp_valid), 32'd1);
      check("bp_y", 32'(resp_y), 32'h55);
      check("bp_id", 32'(resp_id), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 4'b0;
    @(posedge clk); #1;
    resp_ready = 1'b1;
    drain();
    @(negedge clk);
    check("bp_done_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;

    // Mid-operation reset: grant to 2 is aborted while in EXEC
    req_valid = 4'b1111;
    @(negedge clk);
    check("midop_grant", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midop_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("midop_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_seq(4'b1111, 1, '{0, 0, 0, 0, 0});

    repeat (3) @(negedge clk);
    check("final_resp_valid", 32'(resp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
